// File: rtl/chan_scheduler.sv
// Frame scheduler: walks every channel/word of a frame, reads the pixel RAM and
// hands each word to the waveform encoder, then holds a latch gap and pulses done.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start_i; config latched on start
// S_READ  | one-cycle pixel RAM read strobe at {chan, word}
// S_WAIT  | RAM data arrives; captured into the output word register
// S_SEND  | word offered to encoder until valid && ready
// S_LATCH | latch gap after the last word; done_o on its final cycle
module chan_scheduler #(
    parameter int RST_CYCLES = 3000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [7:0]  reg_chan_len_i,
    input  logic [3:0]  reg_chan_cnt_i,
    output logic        ram_rd_en_o,
    output logic [11:0] ram_rd_addr_o,
    input  logic [7:0]  ram_rd_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_data_o,
    output logic [3:0]  out_chan_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int GW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, word_q;
    logic [3:0]      cnt_q, chan_q;
    logic [GW-1:0]   gap_q;
    logic            xfer, word_end, chan_end, gap_end, abort_act;

    assign xfer      = out_valid_o && out_ready_i;
    assign word_end  = (word_q == len_q);
    assign chan_end  = (chan_q == cnt_q);
    assign gap_end   = (gap_q == GAP_LAST);
    assign abort_act = abort_i && (state_q != S_IDLE);

    assign ram_rd_addr_o = {chan_q, word_q};
    assign busy_o        = (state_q != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ram_rd_en_o = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_READ;
            end
            S_READ: begin
                ram_rd_en_o = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (xfer) state_d = (word_end && chan_end) ? S_LATCH : S_READ;
            end
            S_LATCH: begin
                if (gap_end) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // abort overrides everything, including the final done cycle
        if (abort_act) begin
            state_d     = S_IDLE;
            ram_rd_en_o = 1'b0;
            done_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q       <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            chan_q      <= '0;
            gap_q       <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_chan_o  <= '0;
            out_last_o  <= 1'b0;
        end else if (abort_act) begin
            out_valid_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q  <= reg_chan_len_i;
                        cnt_q  <= reg_chan_cnt_i;
                        word_q <= '0;
                        chan_q <= '0;
                    end
                end
                S_WAIT: begin
                    out_data_o  <= ram_rd_data_i;
                    out_valid_o <= 1'b1;
                    out_chan_o  <= chan_q;
                    out_last_o  <= word_end;
                end
                S_SEND: begin
                    if (xfer) begin
                        out_valid_o <= 1'b0;
                        if (!word_end) begin
                            word_q <= word_q + 8'd1;
                        end else if (!chan_end) begin
                            word_q <= '0;
                            chan_q <= chan_q + 4'd1;
                        end else begin
                            gap_q <= '0;
                        end
                    end
                end
                S_LATCH: begin
                    gap_q <= gap_q + GW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
